// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the two-port memory arbiter.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Default number of back-to-back accesses one port may take while the
    // other port is waiting.
    localparam int BURST_MAX_DEF = 4;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Index of a requesting port (0 = CPU data side, 1 = loader/debug side).
    typedef logic port_idx_t;

    // Width of a counter that must hold 0 .. n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Purpose: clearable saturating counter of accesses made in the current ownership burst.
// Latency: count updates at the clock edge closing the access; at_max_o is a decode of the register.
// Backpressure: none; clr_i has priority over inc_i, increments stop at MAX-1.
//
// Ports:
//   clk, n_rst  clock and synchronous active-low reset
//   clr_i       restart the burst (entry into an ownership state)
//   inc_i       one access completes this cycle
//   at_max_o    counter holds MAX-1, i.e. the burst quota is used up
module mem_arb_burst_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int W = cnt_width(MAX);
    localparam logic [W-1:0] CNT_TOP = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_o = (cnt_q == CNT_TOP);

    // Saturation keeps a lone requester sitting at the quota: it keeps the
    // grant, but hands over right after its next access once the other port
    // starts requesting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Purpose: two-port arbiter sharing one single-cycle memory between CPU port 0 and loader port 1.
// Latency: grant registered one edge after request; access data/read data combinational in the grant cycle.
// Backpressure: a port waits while gnt is low; burst quota BURST_MAX forces a handover when both request.
//
// Ports:
//   clk, n_rst                 clock and synchronous active-low reset
//   reqX, weX, addrX, wdataX   request, write enable, byte address, write data of port X
//   gntX                       port X owns the memory this cycle (registered)
//   rdataX                     read data for port X, valid in its read-access cycle, else 0
//   MA, MWD, MWR, MOE          memory address, write data, write strobe, output enable
//   MRD                        memory read data, combinational from MA
//   acc_cntX                   completed accesses of port X (saturating)
//
// Build option: define MEM_ARB_STATS_EN to implement the per-port access
// counters; without it acc_cnt0/acc_cnt1 read 0 and no counter flops exist.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] MA,
    output logic [31:0] MWD,
    output logic        MWR,
    output logic        MOE,
    input  logic [31:0] MRD,
    output logic [15:0] acc_cnt0,
    output logic [15:0] acc_cnt1
);

    arb_state_e state_q;
    arb_state_e state_d;
    port_idx_t  last_gnt_q;
    port_idx_t  last_gnt_d;

    logic acc0;
    logic acc1;
    logic burst_clr;
    logic burst_at_max;

    // Grants are pure state decodes, so they can never both be high.
    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);

    // An access needs both ownership and a live request; an owner that has
    // dropped its request spends this cycle releasing the memory.
    assign acc0 = gnt0 && req0;
    assign acc1 = gnt1 && req1;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    // Tie goes to the port that did not own the memory last.
                    state_d = (last_gnt_q == 1'b1) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d    = req1 ? OWN1 : IDLE;
                    last_gnt_d = 1'b0;
                end else if (req1 && burst_at_max) begin
                    state_d    = OWN1;
                    last_gnt_d = 1'b0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d    = req0 ? OWN0 : IDLE;
                    last_gnt_d = 1'b1;
                end else if (req0 && burst_at_max) begin
                    state_d    = OWN0;
                    last_gnt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // A new burst starts on every entry into an ownership state, including a
    // direct OWN0 <-> OWN1 handover.
    assign burst_clr = ((state_d == OWN0) || (state_d == OWN1)) && (state_d != state_q);

    mem_arb_burst_cnt #(
        .MAX (BURST_MAX)
    ) u_burst_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr_i    (burst_clr),
        .inc_i    (acc0 || acc1),
        .at_max_o (burst_at_max)
    );

    // Memory-side mux: only the accessing port reaches the memory pins; with
    // no access everything is parked at zero.
    always_comb begin
        MA     = '0;
        MWD    = '0;
        MWR    = 1'b0;
        MOE    = 1'b0;
        rdata0 = '0;
        rdata1 = '0;
        if (acc0) begin
            MA  = addr0;
            MWD = wdata0;
            MWR = we0;
            MOE = !we0;
            if (!we0) begin
                rdata0 = MRD;
            end
        end else if (acc1) begin
            MA  = addr1;
            MWD = wdata1;
            MWR = we1;
            MOE = !we1;
            if (!we1) begin
                rdata1 = MRD;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] acc_cnt0_q;
    logic [15:0] acc_cnt0_d;
    logic [15:0] acc_cnt1_q;
    logic [15:0] acc_cnt1_d;

    always_comb begin
        acc_cnt0_d = acc_cnt0_q;
        acc_cnt1_d = acc_cnt1_q;
        if (acc0 && (acc_cnt0_q != 16'hFFFF)) begin
            acc_cnt0_d = acc_cnt0_q + 16'd1;
        end
        if (acc1 && (acc_cnt1_q != 16'hFFFF)) begin
            acc_cnt1_d = acc_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_cnt0_q <= '0;
            acc_cnt1_q <= '0;
        end else begin
            acc_cnt0_q <= acc_cnt0_d;
            acc_cnt1_q <= acc_cnt1_d;
        end
    end

    assign acc_cnt0 = acc_cnt0_q;
    assign acc_cnt1 = acc_cnt1_q;
`else
    assign acc_cnt0 = '0;
    assign acc_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Purpose: self-checking bench for mem_arb with a small word memory and an access scoreboard.
// Latency: expects grant one edge after request and access data in the grant cycle.
// Backpressure: stimulus holds requests until grants appear; every grant wait is cycle-bounded.
module tb_mem_arb;

    logic        clk;
    logic        n_rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] MA, MWD, MRD;
    logic        MWR, MOE;
    logic [15:0] acc_cnt0, acc_cnt1;

    mem_arb #(.BURST_MAX(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .MA       (MA),
        .MWD      (MWD),
        .MWR      (MWR),
        .MOE      (MOE),
        .MRD      (MRD),
        .acc_cnt0 (acc_cnt0),
        .acc_cnt1 (acc_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-word memory: combinational read, write at the closing edge.
    logic [31:0] mem [16];
    assign MRD = mem[MA[5:2]];
    always @(posedge clk) begin
        if (MWR) mem[MA[5:2]] <= MWD;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        bit          port;
        logic        we;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   exp_acc0 = 0;
    int   exp_acc1 = 0;

    function automatic logic [31:0] exp_stat(input int c);
`ifdef MEM_ARB_STATS_EN
        return (c > 65535) ? 32'h0000_FFFF : 32'(c);
`else
        return (c > 65535) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic push(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd);
        exp_t e;
        e.port = p; e.we = we; e.ma = a; e.mwd = d; e.rd = rd;
        sb.push_back(e);
    endtask

    // Monitor: every observed access must match the oldest expected one.
    always @(negedge clk) begin
        chk("gnt_mutex", 32'(gnt0 & gnt1), 32'h0);
        if (MWR || MOE) begin
            if (sb.size() == 0) begin
                chk("unexpected_access", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port",   32'(gnt1), 32'(e.port));
                chk("sb_ma",     MA, e.ma);
                chk("sb_mwd",    MWD, e.mwd);
                chk("sb_mwr",    32'(MWR), 32'(e.we));
                chk("sb_moe",    32'(MOE), 32'(!e.we));
                chk("sb_rdata0", rdata0, (!e.port && !e.we) ? e.rd : 32'h0);
                chk("sb_rdata1", rdata1, ( e.port && !e.we) ? e.rd : 32'h0);
                if (e.port) exp_acc1++; else exp_acc0++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        cyc(1);
        n_rst = 1'b1;
        exp_acc0 = 0;
        exp_acc1 = 0;
    endtask

    // One isolated access from IDLE, with a bounded wait for the grant.
    task automatic single(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd);
        int n;
        push(p, we, a, d, rd);
        if (!p) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!(p ? gnt1 : gnt0) && n < 8);
        chk("gnt_latency", 32'(n), 32'd1);
        cyc(1);
        req0 = 1'b0;
        req1 = 1'b0;
        cyc(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        n_rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cyc(2);

        // Reset state.
        chk("rst_gnt0", 32'(gnt0), 32'h0);
        chk("rst_gnt1", 32'(gnt1), 32'h0);
        chk("rst_ma",   MA, 32'h0);
        chk("rst_mwr",  32'(MWR), 32'h0);
        chk("rst_moe",  32'(MOE), 32'h0);
        chk("rst_acc0", 32'(acc_cnt0), 32'h0);
        chk("rst_acc1", 32'(acc_cnt1), 32'h0);
        n_rst = 1'b1;
        cyc(1);

        // Single writer, then read back word 4.
        single(1'b0, 1'b1, 32'h10, 32'hA5, 32'h0);
        single(1'b0, 1'b0, 32'h10, 32'h0, 32'hA5);
        chk("mem_word4", mem[4], 32'hA5);

        // Read path on port 1: word 1 preloaded with 0x0A.
        single(1'b0, 1'b1, 32'h4, 32'h0A, 32'h0);
        single(1'b1, 1'b0, 32'h4, 32'h0, 32'h0A);

        // Simultaneous first request after reset: port 0 first, 4 + 4 accesses.
        do_reset();
        cyc(1);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 32'h20, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 32'h24, 32'h200, 32'h0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h24; wdata1 = 32'h200;
        cyc(1);
        chk("tie_gnt0", 32'(gnt0), 32'h1);
        chk("tie_gnt1", 32'(gnt1), 32'h0);
        cyc(3);
        chk("burst0_hold", 32'(gnt0), 32'h1);
        cyc(1);
        chk("handoff_gnt1", 32'(gnt1), 32'h1);
        chk("handoff_gnt0", 32'(gnt0), 32'h0);
        cyc(4);
        chk("back_to_p0", 32'(gnt0), 32'h1);
        chk("burst_acc0", 32'(acc_cnt0), exp_stat(exp_acc0));
        chk("burst_acc1", 32'(acc_cnt1), exp_stat(exp_acc1));
        chk("burst_sb_drained", 32'(sb.size()), 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        cyc(3);

        // Lone requester: port 1 keeps the grant for 10 accesses.
        for (int i = 0; i < 10; i++) push(1'b1, 1'b0, 32'h24, 32'h0, 32'h200);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24; wdata1 = 32'h0;
        cyc(1);
        chk("lone_gnt1", 32'(gnt1), 32'h1);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk("lone_hold", 32'(gnt1), 32'h1);
        end
        cyc(1);
        req1 = 1'b0;
        chk("lone_sb_drained", 32'(sb.size()), 32'h0);
        cyc(2);

        // Release handoff: port 0 drops after 2 accesses while port 1 waits.
        push(1'b0, 1'b1, 32'h30, 32'h33, 32'h0);
        push(1'b0, 1'b1, 32'h30, 32'h33, 32'h0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h33;
        cyc(1);
        chk("rel_gnt0", 32'(gnt0), 32'h1);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h30; wdata1 = 32'h0;
        cyc(2);
        req0 = 1'b0;
        @(negedge clk);
        chk("rel_gnt0_hold", 32'(gnt0), 32'h1);
        chk("rel_mwr", 32'(MWR), 32'h0);
        chk("rel_moe", 32'(MOE), 32'h0);
        push(1'b1, 1'b0, 32'h30, 32'h0, 32'h33);
        @(posedge clk);
        #1;
        chk("rel_gnt1", 32'(gnt1), 32'h1);
        cyc(1);
        req1 = 1'b0;
        cyc(2);

        // Reset in the middle of a port 0 burst.
        do_reset();
        cyc(1);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 32'h38, 32'h7, 32'h0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h38; wdata0 = 32'h7;
        cyc(4);
        chk("pre_rst_acc0", 32'(acc_cnt0), exp_stat(3));
        chk("pre_rst_gnt0", 32'(gnt0), 32'h1);
        n_rst = 1'b0;
        cyc(1);
        n_rst = 1'b1;
        exp_acc0 = 0;
        exp_acc1 = 0;
        chk("post_rst_acc0", 32'(acc_cnt0), exp_stat(exp_acc0));
        chk("post_rst_gnt0", 32'(gnt0), 32'h0);
        chk("post_rst_gnt1", 32'(gnt1), 32'h0);
        @(negedge clk);
        chk("post_rst_mwr", 32'(MWR), 32'h0);
        chk("post_rst_moe", 32'(MOE), 32'h0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        cyc(3);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
